control_unit_fsm: RTL and testbench

- Multicycle processor control unit: a Moore FSM driving datapath control from a 4-bit opcode.
- Adds single-level interrupt entry/return, and latches a bit-reversed hardware interrupt vector ("Flipped") that software can read.
- Sits between the instruction register and the datapath muxes and enables.
- Registered state is exposed for debug.

---
 rtl/control_unit_fsm.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fsm.sv
// control_unit_fsm
// Multicycle processor control unit. A Moore FSM decodes the 4-bit opcode into
// datapath mux selects and write enables. It also supports single-level
// interrupt entry and return, and it latches a bit-reversed copy of the
// hardware interrupt lines ("Flipped") that software can read.
//
// Optional feature: macro INTERRUPT_EN.
//   defined   : interrupt entry/return, in-service flag, Flipped register
//   undefined : InterruptTrue=0, END always returns to FETCH, Flipped=0,
//               EPCWrite/FlippedWrite/InterruptWrite stay 0, and opcodes 13/14
//               decode to END
//
// Ports
//   CLK               in   clock, all state on rising edge
//   RST_N             in   synchronous active-low reset
//   Opcode[3:0]       in   instruction opcode field
//   InterruptIn       in   global interrupt enable/request
//   HardwareInterrupt in   per-line interrupt requests [7:0]
//   current_state     out  registered state [4:0]
//   next_state        out  combinational next state [4:0]
//   ALUOp .. FlippedWrite  out  datapath controls, decoded from current_state
//   InterruptTrue     out  combinational interrupt-pending
//   Flipped[7:0]      out  registered bit-reversed HardwareInterrupt
//
// state | meaning
//   0   | FETCH    read instruction, PC += 2
//   1   | DECODE   branch target precompute, dispatch on opcode
//   2   | RALU     register-register ALU op
//   3   | RWB      write ALU result to rd
//   4   | IALU     register-immediate ALU op
//   5   | ADDR     load/store address compute
//   6   | MEMRD    memory read
//   7   | LWB      write loaded data to rt
//   8   | MEMWR    memory write
//   9   | BEQ      branch if equal
//  10   | BNE      branch if not equal
//  11   | JUMP     jump
//  12   | JAL      jump and link to $ra
//  13   | JR       jump to register
//  14   | LUI      load upper immediate
//  15   | RETI     return from interrupt
//  16   | RDINT    read Flipped into rt
//  17   | IWB      write immediate result to rt
//  20   | INT_SAVE save PC to EPC, latch Flipped
//  21   | INT_VEC  jump to interrupt vector, mark in-service
module control_unit_fsm #(
  parameter logic [2:0] INT_VECTOR_SEL = 3'd5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] Opcode,
  input  logic       InterruptIn,
  input  logic [7:0] HardwareInterrupt,
  output logic [4:0] current_state,
  output logic [4:0] next_state,
  output logic [3:0] ALUOp,
  output logic       MemWrite,
  output logic       MemRead,
  output logic [1:0] ALUSrcB,
  output logic       ALUSrcA,
  output logic       GRegWrite,
  output logic       SignExt,
  output logic       IRegWrite,
  output logic [2:0] IorD,
  output logic       PCWrite,
  output logic       PCWriteBeq,
  output logic       PCWriteBne,
  output logic [2:0] PCData,
  output logic [1:0] WriteData,
  output logic [1:0] WriteAddr,
  output logic [1:0] MemWriteData,
  output logic       EPCWrite,
  output logic       InterruptTrue,
  output logic [7:0] Flipped,
  output logic       InterruptWrite,
  output logic       FlippedWrite
);

  localparam logic [4:0] S_FETCH    = 5'd0;
  localparam logic [4:0] S_DECODE   = 5'd1;
  localparam logic [4:0] S_RALU     = 5'd2;
  localparam logic [4:0] S_RWB      = 5'd3;
  localparam logic [4:0] S_IALU     = 5'd4;
  localparam logic [4:0] S_ADDR     = 5'd5;
  localparam logic [4:0] S_MEMRD    = 5'd6;
  localparam logic [4:0] S_LWB      = 5'd7;
  localparam logic [4:0] S_MEMWR    = 5'd8;
  localparam logic [4:0] S_BEQ      = 5'd9;
  localparam logic [4:0] S_BNE      = 5'd10;
  localparam logic [4:0] S_JUMP     = 5'd11;
  localparam logic [4:0] S_JAL      = 5'd12;
  localparam logic [4:0] S_JR       = 5'd13;
  localparam logic [4:0] S_LUI      = 5'd14;
  localparam logic [4:0] S_RETI     = 5'd15;
  localparam logic [4:0] S_RDINT    = 5'd16;
  localparam logic [4:0] S_IWB      = 5'd17;
  localparam logic [4:0] S_INT_SAVE = 5'd20;
  localparam logic [4:0] S_INT_VEC  = 5'd21;

  // Instruction boundary: either start the interrupt sequence or fetch.
  logic [4:0] end_state;

`ifdef INTERRUPT_EN
  logic       in_service;
  logic [7:0] flipped_q;
  logic [7:0] hw_reversed;

  assign InterruptTrue = InterruptIn & (|HardwareInterrupt) & ~in_service;
  assign Flipped       = flipped_q;

  always_comb begin
    hw_reversed = 8'h00;
    for (int i = 0; i < 8; i++) begin
      hw_reversed[i] = HardwareInterrupt[7-i];
    end
  end
`else
  logic unused_int_inputs;

  assign unused_int_inputs = ^{InterruptIn, HardwareInterrupt};
  assign InterruptTrue     = 1'b0;
  assign Flipped           = 8'h00;
`endif

  assign end_state = InterruptTrue ? S_INT_SAVE : S_FETCH;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      current_state <= S_FETCH;
`ifdef INTERRUPT_EN
      in_service    <= 1'b0;
      flipped_q     <= 8'h00;
`endif
    end else begin
      current_state <= next_state;
`ifdef INTERRUPT_EN
      if (FlippedWrite) begin
        flipped_q <= hw_reversed;
      end
      // The only two states that strobe InterruptWrite: INT_VEC sets, RETI clears.
      if (InterruptWrite) begin
        in_service <= (current_state == S_INT_VEC);
      end
`endif
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (current_state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          4'd0, 4'd1, 4'd2, 4'd3: next_state = S_RALU;
          4'd4:                   next_state = S_IALU;
          4'd5, 4'd6:             next_state = S_ADDR;
          4'd7:                   next_state = S_BEQ;
          4'd8:                   next_state = S_BNE;
          4'd9:                   next_state = S_JUMP;
          4'd10:                  next_state = S_JAL;
          4'd11:                  next_state = S_JR;
          4'd12:                  next_state = S_LUI;
`ifdef INTERRUPT_EN
          4'd13:                  next_state = S_RETI;
          4'd14:                  next_state = S_RDINT;
`endif
          default:                next_state = end_state;
        endcase
      end
      S_RALU:     next_state = S_RWB;
      S_RWB:      next_state = end_state;
      S_IALU:     next_state = S_IWB;
      S_ADDR:     next_state = (Opcode == 4'd5) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state = S_LWB;
      S_LWB:      next_state = end_state;
      S_MEMWR:    next_state = end_state;
      S_BEQ:      next_state = end_state;
      S_BNE:      next_state = end_state;
      S_JUMP:     next_state = end_state;
      S_JAL:      next_state = end_state;
      S_JR:       next_state = end_state;
      S_LUI:      next_state = S_IWB;
      S_RETI:     next_state = end_state;
      S_RDINT:    next_state = end_state;
      S_IWB:      next_state = end_state;
`ifdef INTERRUPT_EN
      S_INT_SAVE: next_state = S_INT_VEC;
      S_INT_VEC:  next_state = S_FETCH;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  always_comb begin
    ALUOp          = 4'd0;
    MemWrite       = 1'b0;
    MemRead        = 1'b0;
    ALUSrcB        = 2'd0;
    ALUSrcA        = 1'b0;
    GRegWrite      = 1'b0;
    SignExt        = 1'b0;
    IRegWrite      = 1'b0;
    IorD           = 3'd0;
    PCWrite        = 1'b0;
    PCWriteBeq     = 1'b0;
    PCWriteBne     = 1'b0;
    PCData         = 3'd0;
    WriteData      = 2'd0;
    WriteAddr      = 2'd0;
    MemWriteData   = 2'd0;
    EPCWrite       = 1'b0;
    InterruptWrite = 1'b0;
    FlippedWrite   = 1'b0;
    case (current_state)
      S_FETCH: begin
        MemRead   = 1'b1;
        IRegWrite = 1'b1;
        ALUSrcB   = 2'd1;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        SignExt = 1'b1;
      end
      S_RALU: begin
        ALUSrcA = 1'b1;
        ALUOp   = {2'b00, Opcode[1:0]};
      end
      S_RWB: GRegWrite = 1'b1;
      S_IALU, S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        SignExt = 1'b1;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 3'd1;
      end
      S_LWB: begin
        GRegWrite = 1'b1;
        WriteData = 2'd1;
        WriteAddr = 2'd1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 3'd1;
      end
      S_BEQ: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 4'd1;
        PCWriteBeq = 1'b1;
        PCData     = 3'd1;
      end
      S_BNE: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 4'd1;
        PCWriteBne = 1'b1;
        PCData     = 3'd1;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCData  = 3'd2;
      end
      S_JAL: begin
        PCWrite   = 1'b1;
        PCData    = 3'd2;
        GRegWrite = 1'b1;
        WriteData = 2'd2;
        WriteAddr = 2'd2;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCData  = 3'd3;
      end
      S_LUI: begin
        ALUSrcB = 2'd2;
        ALUOp   = 4'd8;
      end
      S_RETI: begin
        PCWrite = 1'b1;
        PCData  = 3'd4;
`ifdef INTERRUPT_EN
        InterruptWrite = 1'b1;
`endif
      end
      S_RDINT: begin
        GRegWrite = 1'b1;
        WriteData = 2'd3;
        WriteAddr = 2'd1;
      end
      S_IWB: begin
        GRegWrite = 1'b1;
        WriteAddr = 2'd1;
      end
`ifdef INTERRUPT_EN
      S_INT_SAVE: begin
        EPCWrite     = 1'b1;
        FlippedWrite = 1'b1;
      end
      S_INT_VEC: begin
        PCWrite        = 1'b1;
        PCData         = INT_VECTOR_SEL;
        InterruptWrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench for control_unit_fsm. The stimulus process drives inputs
// one cycle at a time and queues the expected state, next state, control word,
// InterruptTrue and Flipped for that cycle. A monitor pops and checks on the
// falling edge. Expectations follow whichever INTERRUPT_EN build is compiled.
module tb_control_unit_fsm;

  logic       CLK;
  logic       RST_N;
  logic [3:0] Opcode;
  logic       InterruptIn;
  logic [7:0] HardwareInterrupt;
  logic [4:0] current_state;
  logic [4:0] next_state;
  logic [3:0] ALUOp;
  logic       MemWrite, MemRead;
  logic [1:0] ALUSrcB;
  logic       ALUSrcA, GRegWrite, SignExt, IRegWrite;
  logic [2:0] IorD;
  logic       PCWrite, PCWriteBeq, PCWriteBne;
  logic [2:0] PCData;
  logic [1:0] WriteData, WriteAddr, MemWriteData;
  logic       EPCWrite, InterruptTrue;
  logic [7:0] Flipped;
  logic       InterruptWrite, FlippedWrite;

  control_unit_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .Opcode(Opcode), .InterruptIn(InterruptIn),
    .HardwareInterrupt(HardwareInterrupt), .current_state(current_state),
    .next_state(next_state), .ALUOp(ALUOp), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .GRegWrite(GRegWrite), .SignExt(SignExt),
    .IRegWrite(IRegWrite), .IorD(IorD), .PCWrite(PCWrite), .PCWriteBeq(PCWriteBeq),
    .PCWriteBne(PCWriteBne), .PCData(PCData), .WriteData(WriteData),
    .WriteAddr(WriteAddr), .MemWriteData(MemWriteData), .EPCWrite(EPCWrite),
    .InterruptTrue(InterruptTrue), .Flipped(Flipped), .InterruptWrite(InterruptWrite),
    .FlippedWrite(FlippedWrite)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  st;
    logic [4:0]  nx;
    bit          chk_nx;
    logic [29:0] ctrl;
    logic        it;
    logic [7:0]  fl;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Control word order: ALUOp MemWrite MemRead ALUSrcB ALUSrcA GRegWrite SignExt
  // IRegWrite IorD PCWrite PCWriteBeq PCWriteBne PCData WriteData WriteAddr
  // MemWriteData EPCWrite InterruptWrite FlippedWrite
  function automatic logic [29:0] exp_ctrl(input logic [4:0] st, input logic [3:0] op);
    logic [3:0] aluop; logic mw, mr; logic [1:0] srcb; logic srca, grw, sext, irw;
    logic [2:0] iord; logic pcw, beq, bne; logic [2:0] pcd; logic [1:0] wd, wa, mwd;
    logic epc, intw, flw;
    aluop = 0; mw = 0; mr = 0; srcb = 0; srca = 0; grw = 0; sext = 0; irw = 0;
    iord = 0; pcw = 0; beq = 0; bne = 0; pcd = 0; wd = 0; wa = 0; mwd = 0;
    epc = 0; intw = 0; flw = 0;
    case (st)
      5'd0:  begin mr = 1; irw = 1; srcb = 1; pcw = 1; end
      5'd1:  begin srcb = 3; sext = 1; end
      5'd2:  begin srca = 1; aluop = {2'b00, op[1:0]}; end
      5'd3:  grw = 1;
      5'd4:  begin srca = 1; srcb = 2; sext = 1; end
      5'd5:  begin srca = 1; srcb = 2; sext = 1; end
      5'd6:  begin mr = 1; iord = 1; end
      5'd7:  begin grw = 1; wd = 1; wa = 1; end
      5'd8:  begin mw = 1; iord = 1; end
      5'd9:  begin srca = 1; aluop = 1; beq = 1; pcd = 1; end
      5'd10: begin srca = 1; aluop = 1; bne = 1; pcd = 1; end
      5'd11: begin pcw = 1; pcd = 2; end
      5'd12: begin pcw = 1; pcd = 2; grw = 1; wd = 2; wa = 2; end
      5'd13: begin pcw = 1; pcd = 3; end
      5'd14: begin srcb = 2; aluop = 8; end
      5'd15: begin pcw = 1; pcd = 4; intw = 1; end
      5'd16: begin grw = 1; wd = 3; wa = 1; end
      5'd17: begin grw = 1; wa = 1; end
      5'd20: begin epc = 1; flw = 1; end
      5'd21: begin pcw = 1; pcd = 5; intw = 1; end
      default: ;
    endcase
    return {aluop, mw, mr, srcb, srca, grw, sext, irw, iord, pcw, beq, bne, pcd,
            wd, wa, mwd, epc, intw, flw};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("current_state", 32'(current_state), 32'(e.st));
      if (e.chk_nx) chk("next_state", 32'(next_state), 32'(e.nx));
      chk("ctrl_word", 32'({ALUOp, MemWrite, MemRead, ALUSrcB, ALUSrcA, GRegWrite,
                            SignExt, IRegWrite, IorD, PCWrite, PCWriteBeq, PCWriteBne,
                            PCData, WriteData, WriteAddr, MemWriteData, EPCWrite,
                            InterruptWrite, FlippedWrite}), 32'(e.ctrl));
      chk("InterruptTrue", 32'(InterruptTrue), 32'(e.it));
      chk("Flipped", 32'(Flipped), 32'(e.fl));
    end
  end

  // Queue one cycle of expectations, then advance to just after the next edge.
  task automatic step(input logic [4:0] st, input logic [4:0] nx, input logic it,
                      input logic [7:0] fl, input bit chk_nx = 1'b1);
    exp_t e;
    e.st = st; e.nx = nx; e.chk_nx = chk_nx; e.it = it; e.fl = fl;
    e.ctrl = exp_ctrl(st, Opcode);
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [7:0] fl_now;

  initial begin
    RST_N = 1'b0; Opcode = 4'd0; InterruptIn = 1'b0; HardwareInterrupt = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    step(0, 1, 0, 8'h00);
    RST_N = 1'b1;

    // R-type loop with interrupts globally off
    HardwareInterrupt = 8'h80;
    repeat (2) begin
      step(0, 1, 0, 8'h00); step(1, 2, 0, 8'h00); step(2, 3, 0, 8'h00); step(3, 0, 0, 8'h00);
    end
    Opcode = 4'd3;
    step(0, 1, 0, 8'h00); step(1, 2, 0, 8'h00); step(2, 3, 0, 8'h00); step(3, 0, 0, 8'h00);

    // BNE with an interrupt pending, then RDINT, RETI, and re-entry after a load
    Opcode = 4'd8; InterruptIn = 1'b1; HardwareInterrupt = 8'h20;
`ifdef INTERRUPT_EN
    step(0, 1, 1, 8'h00); step(1, 10, 1, 8'h00); step(10, 20, 1, 8'h00);
    step(20, 21, 1, 8'h00); step(21, 0, 1, 8'h04);
    Opcode = 4'd14;
    step(0, 1, 0, 8'h04); step(1, 16, 0, 8'h04); step(16, 0, 0, 8'h04);
    Opcode = 4'd13;
    step(0, 1, 0, 8'h04); step(1, 15, 0, 8'h04); step(15, 0, 0, 8'h04);
    Opcode = 4'd5; HardwareInterrupt = 8'h03;
    step(0, 1, 1, 8'h04); step(1, 5, 1, 8'h04); step(5, 6, 1, 8'h04);
    step(6, 7, 1, 8'h04); step(7, 20, 1, 8'h04); step(20, 21, 1, 8'h04);
    step(21, 0, 1, 8'hC0);
    fl_now = 8'hC0;
`else
    step(0, 1, 0, 8'h00); step(1, 10, 0, 8'h00); step(10, 0, 0, 8'h00);
    Opcode = 4'd14;
    step(0, 1, 0, 8'h00); step(1, 0, 0, 8'h00);
    Opcode = 4'd13;
    step(0, 1, 0, 8'h00); step(1, 0, 0, 8'h00);
    Opcode = 4'd5; HardwareInterrupt = 8'h03;
    step(0, 1, 0, 8'h00); step(1, 5, 0, 8'h00); step(5, 6, 0, 8'h00);
    step(6, 7, 0, 8'h00); step(7, 0, 0, 8'h00);
    fl_now = 8'h00;
`endif
    InterruptIn = 1'b0;

    // Remaining opcodes, no interrupt request
    Opcode = 4'd6;
    step(0, 1, 0, fl_now); step(1, 5, 0, fl_now); step(5, 8, 0, fl_now); step(8, 0, 0, fl_now);
    Opcode = 4'd4;
    step(0, 1, 0, fl_now); step(1, 4, 0, fl_now); step(4, 17, 0, fl_now); step(17, 0, 0, fl_now);
    Opcode = 4'd7;
    step(0, 1, 0, fl_now); step(1, 9, 0, fl_now); step(9, 0, 0, fl_now);
    Opcode = 4'd9;
    step(0, 1, 0, fl_now); step(1, 11, 0, fl_now); step(11, 0, 0, fl_now);
    Opcode = 4'd10;
    step(0, 1, 0, fl_now); step(1, 12, 0, fl_now); step(12, 0, 0, fl_now);
    Opcode = 4'd11;
    step(0, 1, 0, fl_now); step(1, 13, 0, fl_now); step(13, 0, 0, fl_now);
    Opcode = 4'd12;
    step(0, 1, 0, fl_now); step(1, 14, 0, fl_now); step(14, 17, 0, fl_now); step(17, 0, 0, fl_now);
    Opcode = 4'd15;
    step(0, 1, 0, fl_now); step(1, 0, 0, fl_now);
    Opcode = 4'd1;
    step(0, 1, 0, fl_now); step(1, 2, 0, fl_now); step(2, 3, 0, fl_now); step(3, 0, 0, fl_now);

    // Reset while in MEMRD
    Opcode = 4'd5;
    step(0, 1, 0, fl_now); step(1, 5, 0, fl_now); step(5, 6, 0, fl_now);
    RST_N = 1'b0;
    step(6, 7, 0, fl_now, 1'b0);
    step(0, 1, 0, 8'h00);
    RST_N = 1'b1;

    // After reset the in-service flag is clear, so a request is taken again
    Opcode = 4'd15; InterruptIn = 1'b1; HardwareInterrupt = 8'h01;
`ifdef INTERRUPT_EN
    step(0, 1, 1, 8'h00); step(1, 20, 1, 8'h00); step(20, 21, 1, 8'h00);
    step(21, 0, 1, 8'h80); step(0, 1, 0, 8'h80);
`else
    step(0, 1, 0, 8'h00); step(1, 0, 0, 8'h00); step(0, 1, 0, 8'h00);
`endif
    InterruptIn = 1'b0;

    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
